// File: rtl/img_ctrl_pkg.sv
// img_ctrl_pkg: shared types and default constants for the block sequencer.
//   state_e          - sequencer FSM states
//   *_DEF            - default parameter values for blk_seq_ctrl
//   max_u()          - elaboration-time max of two unsigned ints
package img_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LATENCY,
        ROUND,
        ENCODE
    } state_e;

    localparam int unsigned PIX_PER_BLK_DEF = 64;
    localparam int unsigned ROUND_LAT_DEF   = 20;
    localparam int unsigned ENC_TIMEOUT_DEF = 255;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// seq_timer: loadable free-running up-counter with terminal-count flag.
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_load         - load i_load_val (takes priority over i_en)
//   i_load_val     - value loaded on i_load
//   i_en           - count enable
//   i_tc_val       - terminal count value
//   o_tc           - high while the count equals i_tc_val
module seq_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_tc_val,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == i_tc_val);

endmodule

// File: rtl/blk_seq_ctrl.sv
// blk_seq_ctrl: block-level sequencer for the compression pipeline.
// Admits one 8x8 pixel block, holds the FDCT in reset between blocks, times the
// fixed pipeline latency, drives the rounding window and encoder start, then
// waits for all three channel encoders before admitting the next block.
//   clk_0, rst_n        - clock, asynchronous active-low reset
//   enable              - admit new blocks
//   pix_valid/pix_ready - pixel handshake
//   dct_2_D_rst         - FDCT reset (active high)
//   start_rounding      - rounding window level, PIX_PER_BLK cycles
//   start_encoder       - one-cycle pulse on the 2nd rounding cycle
//   sync_y/cb/cr        - encoder block-complete pulses
//   blk_done, blk_count - completion pulse and wrapping block counter
//   busy                - state != IDLE
//   timeout_err         - sticky encoder timeout, cleared by clear_err
//   stall_cnt           - LOAD cycles without pix_valid (only with BLK_SEQ_STALL_CNT_EN)
module blk_seq_ctrl
    import img_ctrl_pkg::*;
#(
    parameter int unsigned PIX_PER_BLK = PIX_PER_BLK_DEF,
    parameter int unsigned ROUND_LAT   = ROUND_LAT_DEF,
    parameter int unsigned ENC_TIMEOUT = ENC_TIMEOUT_DEF,
    parameter int unsigned BLK_CNT_W   = 16
) (
    input  logic                 clk_0,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic                 dct_2_D_rst,
    output logic                 start_rounding,
    output logic                 start_encoder,
    input  logic                 sync_y,
    input  logic                 sync_cb,
    input  logic                 sync_cr,
    output logic                 blk_done,
    output logic                 busy,
    output logic [BLK_CNT_W-1:0] blk_count,
    output logic                 timeout_err,
`ifdef BLK_SEQ_STALL_CNT_EN
    output logic [15:0]          stall_cnt,
`endif
    input  logic                 clear_err
);

    localparam int unsigned WIN_W  = $clog2(max_u(ROUND_LAT, PIX_PER_BLK));
    localparam int unsigned TMO_W  = $clog2(ENC_TIMEOUT + 1);
    localparam int unsigned PCNT_W = $clog2(PIX_PER_BLK + 1);

    if (ROUND_LAT < 2) begin : g_bad_round_lat
        $fatal(1, "ROUND_LAT must be >= 2");
    end
    if (PIX_PER_BLK < 2) begin : g_bad_pix_per_blk
        $fatal(1, "PIX_PER_BLK must be >= 2");
    end
    if (ENC_TIMEOUT < 1) begin : g_bad_enc_timeout
        $fatal(1, "ENC_TIMEOUT must be >= 1");
    end

    state_e               r_state, w_state_d;
    logic [PCNT_W-1:0]    r_pix_cnt, w_pix_cnt_d;
    logic [2:0]           r_sync, w_sync_d, w_sync_in, w_sync_all;
    logic                 r_pix_ready, w_pix_ready_d;
    logic                 r_dct_rst, w_dct_rst_d;
    logic                 r_start_rounding, w_start_rounding_d;
    logic                 r_start_encoder, w_start_encoder_d;
    logic                 r_round_first, w_round_first_d;
    logic                 r_blk_done, w_blk_done_d;
    logic                 r_busy;
    logic [BLK_CNT_W-1:0] r_blk_count, w_blk_count_d;
    logic                 r_timeout_err, w_timeout_err_d;
    logic                 w_accept;
    logic                 w_win_load, w_win_tc;
    logic [WIN_W-1:0]     w_win_tc_val;
    logic                 w_tmo_load, w_tmo_tc;

    assign w_accept  = pix_valid & r_pix_ready;
    assign w_sync_in = {sync_cr, sync_cb, sync_y};
    // Same-cycle arrival counts toward completion.
    assign w_sync_all = r_sync | w_sync_in;

    // One timer serves both the latency wait and the rounding window.
    assign w_win_tc_val = (r_state == LATENCY) ? WIN_W'(ROUND_LAT - 1) : WIN_W'(PIX_PER_BLK - 1);

    seq_timer #(
        .WIDTH (WIN_W)
    ) u_win_tmr (
        .i_clk      (clk_0),
        .i_rst_n    (rst_n),
        .i_load     (w_win_load),
        .i_load_val ('0),
        .i_en       (1'b1),
        .i_tc_val   (w_win_tc_val),
        .o_tc       (w_win_tc)
    );

    seq_timer #(
        .WIDTH (TMO_W)
    ) u_tmo_tmr (
        .i_clk      (clk_0),
        .i_rst_n    (rst_n),
        .i_load     (w_tmo_load),
        .i_load_val ('0),
        .i_en       (1'b1),
        .i_tc_val   (TMO_W'(ENC_TIMEOUT - 1)),
        .o_tc       (w_tmo_tc)
    );

    always_comb begin
        w_state_d          = r_state;
        w_pix_cnt_d        = r_pix_cnt;
        w_sync_d           = r_sync;
        w_pix_ready_d      = 1'b0;
        w_dct_rst_d        = r_dct_rst;
        w_start_rounding_d = 1'b0;
        w_start_encoder_d  = 1'b0;
        w_round_first_d    = 1'b0;
        w_blk_done_d       = 1'b0;
        w_blk_count_d      = r_blk_count;
        w_timeout_err_d    = r_timeout_err & ~clear_err;
        w_win_load         = 1'b0;
        w_tmo_load         = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_pix_ready_d = enable;
                if (w_accept) begin
                    w_state_d     = LOAD;
                    w_pix_cnt_d   = PCNT_W'(1);
                    w_dct_rst_d   = 1'b0;
                    w_pix_ready_d = 1'b1;
                end
            end
            LOAD: begin
                w_pix_ready_d = 1'b1;
                if (w_accept) begin
                    w_pix_cnt_d = r_pix_cnt + 1'b1;
                    if (r_pix_cnt == PCNT_W'(PIX_PER_BLK - 1)) begin
                        w_state_d     = LATENCY;
                        w_pix_ready_d = 1'b0;
                        w_win_load    = 1'b1;
                    end
                end
            end
            LATENCY: begin
                if (w_win_tc) begin
                    w_state_d          = ROUND;
                    w_start_rounding_d = 1'b1;
                    w_round_first_d    = 1'b1;
                    w_win_load         = 1'b1;
                    w_sync_d           = '0;
                end
            end
            ROUND: begin
                w_sync_d = w_sync_all;
                // Encoder start trails the rounding register by one cycle.
                w_start_encoder_d = r_round_first;
                if (w_win_tc) begin
                    w_state_d  = ENCODE;
                    w_tmo_load = 1'b1;
                end else begin
                    w_start_rounding_d = 1'b1;
                end
            end
            ENCODE: begin
                w_sync_d = w_sync_all;
                if (&w_sync_all) begin
                    w_state_d     = IDLE;
                    w_blk_done_d  = 1'b1;
                    w_blk_count_d = r_blk_count + 1'b1;
                    w_dct_rst_d   = 1'b1;
                end else if (w_tmo_tc) begin
                    w_state_d       = IDLE;
                    w_timeout_err_d = 1'b1;
                    w_dct_rst_d     = 1'b1;
                end
            end
            default: begin
                w_state_d   = IDLE;
                w_dct_rst_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_0 or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_pix_cnt        <= '0;
            r_sync           <= '0;
            r_pix_ready      <= 1'b0;
            r_dct_rst        <= 1'b1;
            r_start_rounding <= 1'b0;
            r_start_encoder  <= 1'b0;
            r_round_first    <= 1'b0;
            r_blk_done       <= 1'b0;
            r_busy           <= 1'b0;
            r_blk_count      <= '0;
            r_timeout_err    <= 1'b0;
        end else begin
            r_state          <= w_state_d;
            r_pix_cnt        <= w_pix_cnt_d;
            r_sync           <= w_sync_d;
            r_pix_ready      <= w_pix_ready_d;
            r_dct_rst        <= w_dct_rst_d;
            r_start_rounding <= w_start_rounding_d;
            r_start_encoder  <= w_start_encoder_d;
            r_round_first    <= w_round_first_d;
            r_blk_done       <= w_blk_done_d;
            r_busy           <= (w_state_d != IDLE);
            r_blk_count      <= w_blk_count_d;
            r_timeout_err    <= w_timeout_err_d;
        end
    end

`ifdef BLK_SEQ_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk_0 or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_state == IDLE && w_state_d == LOAD) begin
            r_stall_cnt <= '0;
        end else if (r_state == LOAD && !pix_valid && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign pix_ready      = r_pix_ready;
    assign dct_2_D_rst    = r_dct_rst;
    assign start_rounding = r_start_rounding;
    assign start_encoder  = r_start_encoder;
    assign blk_done       = r_blk_done;
    assign busy           = r_busy;
    assign blk_count      = r_blk_count;
    assign timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_blk_seq_ctrl.sv
// tb_blk_seq_ctrl: self-checking bench for blk_seq_ctrl with a completion scoreboard.
module tb_blk_seq_ctrl;

    localparam int unsigned PIX  = 64;
    localparam int unsigned RLAT = 20;
    localparam int unsigned ETMO = 255;
    localparam int unsigned CW   = 16;

    logic          clk_0 = 1'b0;
    logic          rst_n = 1'b1;
    logic          enable = 1'b0;
    logic          pix_valid = 1'b0;
    logic          sync_y = 1'b0;
    logic          sync_cb = 1'b0;
    logic          sync_cr = 1'b0;
    logic          clear_err = 1'b0;
    logic          pix_ready, dct_2_D_rst, start_rounding, start_encoder;
    logic          blk_done, busy, timeout_err;
    logic [CW-1:0] blk_count;
`ifdef BLK_SEQ_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    blk_seq_ctrl #(
        .PIX_PER_BLK (PIX),
        .ROUND_LAT   (RLAT),
        .ENC_TIMEOUT (ETMO),
        .BLK_CNT_W   (CW)
    ) dut (
        .clk_0          (clk_0),
        .rst_n          (rst_n),
        .enable         (enable),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .dct_2_D_rst    (dct_2_D_rst),
        .start_rounding (start_rounding),
        .start_encoder  (start_encoder),
        .sync_y         (sync_y),
        .sync_cb        (sync_cb),
        .sync_cr        (sync_cr),
        .blk_done       (blk_done),
        .busy           (busy),
        .blk_count      (blk_count),
        .timeout_err    (timeout_err),
`ifdef BLK_SEQ_STALL_CNT_EN
        .stall_cnt      (stall_cnt),
`endif
        .clear_err      (clear_err)
    );

    always #5 clk_0 = ~clk_0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk_0) cyc++;

    typedef struct {
        bit            done;
        logic [CW-1:0] count;
    } exp_t;

    exp_t sb_q[$];
    int   model_cnt = 0;

    // Monitor bookkeeping (written only by the monitor process).
    int last_acc   = 0;
    int first_acc  = 0;
    int sr_rise    = 0;
    int enc_pulses = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_0);
        #1;
    endtask

    initial begin : monitor
        bit   sr_prev  = 1'b0;
        bit   err_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk_0);
            if (!rst_n) begin
                sr_prev  = 1'b0;
                err_prev = 1'b0;
            end else begin
                if (pix_valid && pix_ready) begin
                    if (!busy) first_acc = cyc;
                    last_acc = cyc;
                end
                if (start_rounding && !sr_prev) begin
                    sr_rise = cyc;
                    check("sr_rise_after_last_accept", cyc - last_acc, RLAT + 1);
                end
                if (!start_rounding && sr_prev) check("sr_width", cyc - sr_rise, PIX);
                if (start_encoder) begin
                    enc_pulses++;
                    check("se_position", cyc - sr_rise, 1);
                end
                if (blk_done) begin
                    if (sb_q.size() == 0) begin
                        check("blk_done_unexpected", blk_done, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_expect_done", 1, e.done);
                        check("sb_blk_count", blk_count, e.count);
                    end
                end
                if (timeout_err && !err_prev) begin
                    if (sb_q.size() == 0) begin
                        check("timeout_unexpected", timeout_err, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_expect_timeout", 0, e.done);
                        check("sb_tmo_blk_count", blk_count, e.count);
                    end
                end
                sr_prev  = start_rounding;
                err_prev = timeout_err;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: time %0t, required finish before 2000000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic send_block(input int gaps, input int drop_at);
        int sent     = 0;
        int steps    = 0;
        int last_gap = -1;
        bit acc;
        while (sent < PIX && steps < 400) begin
            if (gaps > 0 && sent > 0 && sent % 5 == 0 && last_gap != sent) begin
                pix_valid = 1'b0;
                gaps--;
                last_gap = sent;
            end else begin
                pix_valid = 1'b1;
            end
            if (sent == drop_at) enable = 1'b0;
            acc = pix_valid && pix_ready;
            tick();
            steps++;
            if (acc) sent++;
        end
        pix_valid = 1'b0;
        check("pixels_accepted", sent, PIX);
        check("load_done_ready", pix_ready, 0);
        check("load_done_dct_rst", dct_2_D_rst, 0);
        check("load_done_busy", busy, 1);
    endtask

    // Returns at the first ENCODE cycle.
    task automatic wait_encode();
        int n = 0;
        while (!start_rounding && n < 100) begin
            tick();
            n++;
        end
        while (start_rounding && n < 200) begin
            tick();
            n++;
        end
        check("reached_encode", (n < 200) && !start_rounding, 1);
    endtask

    task automatic do_syncs(input bit stagger, input int dly);
        repeat (dly) tick();
        if (!stagger) begin
            {sync_y, sync_cb, sync_cr} = 3'b111;
            tick();
            {sync_y, sync_cb, sync_cr} = 3'b000;
        end else begin
            sync_y = 1'b1;
            tick();
            sync_y = 1'b0;
            repeat (4) tick();
            check("no_done_after_y", blk_done, 0);
            sync_cb = 1'b1;
            tick();
            sync_cb = 1'b0;
            repeat (4) tick();
            check("no_done_after_cb", blk_done, 0);
            sync_cr = 1'b1;
            tick();
            sync_cr = 1'b0;
        end
        check("done_after_last_sync", blk_done, 1);
        check("done_dct_rst", dct_2_D_rst, 1);
        check("done_busy", busy, 0);
        tick();
        check("done_one_shot", blk_done, 0);
        check("ready_after_done", pix_ready, enable);
    endtask

    task automatic run_block(input int gaps, input int drop_at, input bit stagger, input int dly);
        exp_t e;
        int   enc_base;
        model_cnt++;
        e.done  = 1'b1;
        e.count = CW'(model_cnt);
        sb_q.push_back(e);
        enc_base = enc_pulses;
        send_block(gaps, drop_at);
        wait_encode();
        if (gaps == 0) check("sr_rise_after_first_accept", sr_rise - first_acc, 84);
        do_syncs(stagger, dly);
        check("enc_pulse_count", enc_pulses - enc_base, 1);
`ifdef BLK_SEQ_STALL_CNT_EN
        check("stall_cnt", stall_cnt, gaps);
`endif
    endtask

    initial begin : main
        exp_t e;
        int   n;

        #1 rst_n = 1'b0;
        #1;
        check("rst_pix_ready", pix_ready, 0);
        check("rst_dct_rst", dct_2_D_rst, 1);
        check("rst_start_rounding", start_rounding, 0);
        check("rst_start_encoder", start_encoder, 0);
        check("rst_blk_done", blk_done, 0);
        check("rst_busy", busy, 0);
        check("rst_blk_count", blk_count, 0);
        check("rst_timeout_err", timeout_err, 0);
        repeat (3) @(posedge clk_0);
        #1 rst_n = 1'b1;
        enable = 1'b1;
        tick();

        // Gapless block, simultaneous syncs 30 cycles into ENCODE.
        run_block(0, -1, 1'b0, 30);
        check("blk_count_1", blk_count, 1);

        // Ten single-cycle gaps, staggered syncs.
        run_block(10, -1, 1'b1, 3);

        // Encoder timeout: sync_cr never arrives.
        e.done  = 1'b0;
        e.count = CW'(model_cnt);
        sb_q.push_back(e);
        send_block(0, -1);
        wait_encode();
        n = 0;
        while (!timeout_err && n < 400) begin
            sync_y  = (n == 3);
            sync_cb = (n == 3);
            tick();
            n++;
        end
        sync_y  = 1'b0;
        sync_cb = 1'b0;
        check("tmo_encode_cycles", n, ETMO);
        check("tmo_busy", busy, 0);
        check("tmo_blk_done", blk_done, 0);
        check("tmo_blk_count", blk_count, model_cnt);
        tick();
        check("tmo_sticky", timeout_err, 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("tmo_cleared", timeout_err, 0);

        // Reset in the middle of LATENCY.
        send_block(0, -1);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        model_cnt = 0;
        check("midrst_pix_ready", pix_ready, 0);
        check("midrst_dct_rst", dct_2_D_rst, 1);
        check("midrst_busy", busy, 0);
        check("midrst_blk_count", blk_count, 0);
        check("midrst_start_rounding", start_rounding, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_block(0, -1, 1'b0, 5);
        check("post_rst_blk_count", blk_count, 1);

        // Enable dropped mid-LOAD: block finishes, then no admission until enable.
        run_block(0, 30, 1'b0, 2);
        pix_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_disabled_ready", pix_ready, 0);
            check("idle_disabled_busy", busy, 0);
        end
        pix_valid = 1'b0;
        enable = 1'b1;
        tick();
        check("idle_enabled_ready", pix_ready, 1);
        repeat (2) tick();
        check("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/blk_seq_ctrl.md
Name: blk_seq_ctrl

Overview:
- Block-level sequencer for the compression pipeline: RGB->YCbCr transform, 2-D FDCT, quantize/round, then per-channel entropy encoders.
- Accepts one 8x8 block of pixels (64 beats) via valid/ready.
- Holds the FDCT in reset between blocks, times the fixed pipeline latency, and issues start_rounding and start_encoder.
- Waits for sync_y/sync_cb/sync_cr from the encoders before admitting the next block.

Parameters:
- PIX_PER_BLK, 64, pixels per block; also the length of the rounding window in cycles.
- ROUND_LAT, 20, cycles from the last accepted pixel to start_rounding rising (84 total with gapless input).
- ENC_TIMEOUT, 255, maximum cycles in ENCODE before error abort.
- BLK_CNT_W, 16, width of the completed-block counter.

Ports:
- clk_0  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  admit new blocks when high.
- pix_valid  in  1  upstream pixel (R_in/G_in/B_in) valid.
- pix_ready  out  1  controller accepts pixel this cycle.
- dct_2_D_rst  out  1  FDCT reset, active high.
- start_rounding  out  1  rounding window level.
- start_encoder  out  1  one-cycle encoder start pulse.
- sync_y  in  1  Y encoder block-complete.
- sync_cb  in  1  Cb encoder block-complete.
- sync_cr  in  1  Cr encoder block-complete.
- blk_done  out  1  one-cycle pulse on block completion.
- busy  out  1  high whenever state != IDLE.
- blk_count  out  BLK_CNT_W  number of completed blocks, wraps.
- timeout_err  out  1  sticky encoder timeout flag.
- clear_err  in  1  clears timeout_err.

Behaviour:
- Clocking and reset: one clock (clk_0); reset is asynchronous, active-low (rst_n).
- Reset values: state=IDLE, dct_2_D_rst=1, pix_ready=0, start_rounding=0, start_encoder=0, blk_done=0, busy=0, blk_count=0, timeout_err=0. All outputs are registered.
- Accept rule: a pixel is accepted on a cycle with pix_valid & pix_ready.
- IDLE:
  - pix_ready = enable.
  - On accept: pix_cnt=1, dct_2_D_rst=0 from the next cycle, go LOAD.
- LOAD:
  - pix_ready=1; enable is ignored until the block finishes.
  - Input gaps (pix_valid=0) stall pix_cnt.
  - On the accept that makes pix_cnt==PIX_PER_BLK: pix_ready=0, lat_cnt=0, go LATENCY.
- LATENCY:
  - pix_ready=0; lat_cnt increments each cycle.
  - When lat_cnt==ROUND_LAT-1: go ROUND, start_rounding=1 the next cycle.
  - start_rounding therefore rises exactly ROUND_LAT cycles after the last-accept edge.
- ROUND:
  - start_rounding held high for exactly PIX_PER_BLK cycles.
  - start_encoder pulses once, on the 2nd cycle of ROUND (one-cycle rounding register latency).
  - sync_* sticky flags are cleared on ROUND entry and capture from ROUND entry onward.
  - After PIX_PER_BLK cycles: start_rounding=0, tmo_cnt=0, go ENCODE.
- ENCODE:
  - Capture any sync_* pulse into its sticky flag; simultaneous syncs are legal.
  - When all three flags are set (including same-cycle arrival): blk_done=1 for one cycle, blk_count++ (wraps at 2^BLK_CNT_W), go IDLE, dct_2_D_rst=1.
  - If tmo_cnt reaches ENC_TIMEOUT first: timeout_err=1, go IDLE without blk_done, blk_count unchanged.
- Syncs outside ROUND/ENCODE are ignored.
- clear_err clears timeout_err. If a timeout and clear_err occur in the same cycle, the set wins.
- Back-to-back blocks: pix_ready can reassert the cycle after blk_done if enable=1. There is no overlap between blocks.
- Reset mid-operation: immediate return to reset values. Partial block discarded, no blk_done.
- Parameter legality: ROUND_LAT>=2, PIX_PER_BLK>=2; enforced by elaboration assertions.

Optional Feature:
- Macro: BLK_SEQ_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0], counting LOAD cycles with pix_valid=0, saturating at 16'hFFFF.
  - stall_cnt clears on IDLE->LOAD and holds its value after the block until the next block starts.
- Undefined: the port and counter are absent; all other behaviour identical.

Decomposition:
- Package img_ctrl_pkg holds:
  - state enum {IDLE, LOAD, LATENCY, ROUND, ENCODE};
  - default constants PIX_PER_BLK_DEF=64, ROUND_LAT_DEF=20, ENC_TIMEOUT_DEF=255.
- One natural sub-module, seq_timer: a loadable up-counter with terminal-count flag.
  - Instantiated twice: latency/rounding window, and encoder timeout.
- Pixel count stays inline.

Test Plan:
- Reset, then a gapless 64-pixel block with syncs arriving 30 cycles into ENCODE -> start_rounding rises 84 cycles after first accept and stays high 64 cycles; start_encoder pulses on its 2nd cycle; blk_done once; blk_count=1.
- Same block with 10 single-cycle pix_valid gaps -> start_rounding rises 20 cycles after the 64th accept; with BLK_SEQ_STALL_CNT_EN, stall_cnt=10.
- sync_y, sync_cb, sync_cr in the same cycle vs. staggered by 5 cycles -> single blk_done one cycle after the last sync in both cases.
- Withhold sync_cr -> timeout_err=1 after 255 ENCODE cycles, return to IDLE, blk_count unchanged; pulse clear_err -> timeout_err=0.
- rst_n low in the middle of LATENCY -> all outputs at reset values immediately; next block runs normally.
- enable dropped mid-LOAD -> block completes; pix_ready stays 0 in IDLE until enable=1.
